mi_arbiter: RTL and testbench

Transaction-level arbiter that shares the single `qpi_memctrl` memory interface (`mi_*`) between N requesters, e.g. `memtest` and a future LCD frame-fetch DMA. It sits between the requesters and the QPI controller in the `clk_1x` domain. It grants one whole burst at a time, from command accept to the last data beat, and steers that burst's write/read data handshakes to the granted requester.

---
 rtl/mi_arb_pkg.sv | 9 +
 rtl/mi_arb_pick.sv | 26 ++
 rtl/mi_arbiter.sv | 139 +++++++++++++
 tb/tb_mi_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mi_arb_pkg.sv
// Shared constants for the mi_* interface arbiter: FSM encodings and bus widths.
package mi_arb_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam int MI_LEN_W = 7;
    localparam int MI_DW    = 32;
endpackage

// File: rtl/mi_arb_pick.sv
// Combinational requester picker: first set bit of req, searching upward from ptr
// and wrapping at N. Fixed priority is obtained by tying ptr to 0.
module mi_arb_pick #(
    parameter int N  = 2,
    parameter int GW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic          any,
    output logic [GW-1:0] idx
);
    always_comb begin
        int j;
        j   = 0;
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = j[GW-1:0];
            end
        end
    end
endmodule

// File: rtl/mi_arbiter.sv
// Burst-level arbiter sharing one mi_* memory interface between N requesters.
// Define MI_ARB_RR_EN for round-robin arbitration; otherwise index 0 has fixed priority.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | nothing granted, all outputs 0, pick a winner if any valid
// ST_CMD  | command of grant presented downstream, waiting for mi_ready
// ST_DATA | burst in flight, data handshakes steered to grant
module mi_arbiter
    import mi_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int AW = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N*AW-1:0]       req_addr,
    input  logic [N*MI_LEN_W-1:0] req_len,
    input  logic [N-1:0]          req_rw,
    input  logic [N-1:0]          req_valid,
    output logic [N-1:0]          req_ready,
    input  logic [N*MI_DW-1:0]    req_wdata,
    output logic [N-1:0]          req_wack,
    output logic [N-1:0]          req_wlast,
    output logic [MI_DW-1:0]      req_rdata,
    output logic [N-1:0]          req_rstb,
    output logic [N-1:0]          req_rlast,
    output logic [AW-1:0]         mi_addr,
    output logic [MI_LEN_W-1:0]   mi_len,
    output logic                  mi_rw,
    output logic                  mi_valid,
    input  logic                  mi_ready,
    output logic [MI_DW-1:0]      mi_wdata,
    input  logic                  mi_wack,
    input  logic                  mi_wlast,
    input  logic [MI_DW-1:0]      mi_rdata,
    input  logic                  mi_rstb,
    input  logic                  mi_rlast
);
    localparam int GW = (N > 1) ? $clog2(N) : 1;

    logic [1:0]    state;
    logic [GW-1:0] grant;
    logic          rw_q;
    logic          active, in_cmd, accept, w_done, r_done;
    logic          g_valid, g_rw;
    logic [N-1:0]  gsel;
    logic          pick_any;
    logic [GW-1:0] pick_idx, pick_ptr;

`ifdef MI_ARB_RR_EN
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] grant_inc;
    assign grant_inc = (grant == GW'(N-1)) ? '0 : grant + 1'b1;
    assign pick_ptr  = rr_ptr;
`else
    assign pick_ptr  = '0;
`endif

    mi_arb_pick #(.N(N), .GW(GW)) u_pick (
        .req (req_valid),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign active = (state != ST_IDLE);
    assign in_cmd = (state == ST_CMD);

    // Every mux is gated by active so an idle arbiter drives all zeros.
    always_comb begin
        mi_addr  = '0;
        mi_len   = '0;
        mi_rw    = 1'b0;
        mi_wdata = '0;
        g_valid  = 1'b0;
        g_rw     = 1'b0;
        gsel     = '0;
        for (int i = 0; i < N; i++) begin
            if (active && grant == GW'(i)) begin
                gsel[i]  = 1'b1;
                mi_addr  = req_addr[i*AW +: AW];
                mi_len   = req_len[i*MI_LEN_W +: MI_LEN_W];
                mi_rw    = req_rw[i];
                mi_wdata = req_wdata[i*MI_DW +: MI_DW];
                g_valid  = req_valid[i];
                g_rw     = req_rw[i];
            end
        end
    end

    assign mi_valid  = in_cmd & g_valid;
    assign accept    = mi_valid & mi_ready;
    assign w_done    = mi_wack & mi_wlast;
    assign r_done    = mi_rstb & mi_rlast;

    assign req_ready = gsel & {N{in_cmd & mi_ready}};
    assign req_wack  = gsel & {N{mi_wack}};
    assign req_wlast = gsel & {N{mi_wlast}};
    assign req_rstb  = gsel & {N{mi_rstb}};
    assign req_rlast = gsel & {N{mi_rlast}};
    assign req_rdata = active ? mi_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            grant <= '0;
            rw_q  <= 1'b0;
`ifdef MI_ARB_RR_EN
            rr_ptr <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant <= pick_idx;
                        state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (accept) begin
                        rw_q <= g_rw;
`ifdef MI_ARB_RR_EN
                        rr_ptr <= grant_inc;
`endif
                        // a last beat landing on the accept cycle ends the burst here
                        state <= (g_rw ? r_done : w_done) ? ST_IDLE : ST_DATA;
                    end else if (!g_valid) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (rw_q ? r_done : w_done) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mi_arbiter.sv
// Directed self-checking bench for mi_arbiter (N=2); expectations follow MI_ARB_RR_EN.
module tb_mi_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N*AW-1:0] req_addr;
    logic [N*7-1:0]  req_len;
    logic [N-1:0]    req_rw, req_valid, req_ready;
    logic [N*32-1:0] req_wdata;
    logic [N-1:0]    req_wack, req_wlast, req_rstb, req_rlast;
    logic [31:0]     req_rdata;
    logic [AW-1:0]   mi_addr;
    logic [6:0]      mi_len;
    logic            mi_rw, mi_valid, mi_ready;
    logic [31:0]     mi_wdata, mi_rdata;
    logic            mi_wack, mi_wlast, mi_rstb, mi_rlast;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mi_arbiter #(.N(N), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_rw    (req_rw),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wdata (req_wdata),
        .req_wack  (req_wack),
        .req_wlast (req_wlast),
        .req_rdata (req_rdata),
        .req_rstb  (req_rstb),
        .req_rlast (req_rlast),
        .mi_addr   (mi_addr),
        .mi_len    (mi_len),
        .mi_rw     (mi_rw),
        .mi_valid  (mi_valid),
        .mi_ready  (mi_ready),
        .mi_wdata  (mi_wdata),
        .mi_wack   (mi_wack),
        .mi_wlast  (mi_wlast),
        .mi_rdata  (mi_rdata),
        .mi_rstb   (mi_rstb),
        .mi_rlast  (mi_rlast)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic clear_dn;
        mi_ready = 1'b0;
        mi_wack  = 1'b0;
        mi_wlast = 1'b0;
        mi_rstb  = 1'b0;
        mi_rlast = 1'b0;
        mi_rdata = '0;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        clear_dn();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    int exp_order[6];
    int rem[2];
    int idx, owner, cyc;
    bit pend;

    initial begin
`ifdef MI_ARB_RR_EN
        exp_order = '{0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 1, 1, 1};
`endif
        rst_n     = 1'b0;
        req_addr  = {32'h0000_2222, 32'h0000_1111};
        req_len   = {7'd5, 7'd9};
        req_rw    = 2'b11;
        req_valid = 2'b11;
        req_wdata = {32'hCAFE_0001, 32'hCAFE_0000};
        clear_dn();
        mi_rstb   = 1'b1;
        mi_wack   = 1'b1;
        repeat (2) @(posedge clk);

        // reset: requests present but every output must be gated off
        sample();
        check_eq("rst_mi_valid", mi_valid, 0);
        check_eq("rst_mi_addr", mi_addr, 0);
        check_eq("rst_mi_wdata", mi_wdata, 0);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_req_wack", req_wack, 0);
        check_eq("rst_req_rstb", req_rstb, 0);
        req_valid = '0;
        clear_dn();
        tick();
        rst_n = 1'b1;
        tick();

        // single 4-word write from req0
        req_addr[31:0] = 32'h100;
        req_len[6:0]   = 7'd3;
        req_rw[0]      = 1'b0;
        req_valid      = 2'b01;
        sample();
        check_eq("t1_valid_idle", mi_valid, 0);
        tick();
        mi_ready = 1'b1;
        sample();
        check_eq("t1_mi_valid", mi_valid, 1);
        check_eq("t1_mi_addr", mi_addr, 32'h100);
        check_eq("t1_mi_len", mi_len, 3);
        check_eq("t1_mi_rw", mi_rw, 0);
        check_eq("t1_req_ready", req_ready, 2'b01);
        tick();
        mi_ready  = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            req_wdata[31:0] = 32'hA0 + i;
            mi_wack  = 1'b1;
            mi_wlast = (i == 3);
            sample();
            check_eq("t1_data_valid", mi_valid, 0);
            check_eq("t1_wdata", mi_wdata, 32'hA0 + i);
            check_eq("t1_wack", req_wack, 2'b01);
            check_eq("t1_wlast", req_wlast, (i == 3) ? 2'b01 : 2'b00);
            tick();
        end
        clear_dn();
        sample();
        check_eq("t1_end_idle", mi_addr, 0);
        check_eq("t1_end_wack", req_wack, 0);

        // simultaneous reads: three len-0 bursts from each requester
        do_reset();
        req_addr  = {32'h2000, 32'h1000};
        req_len   = '0;
        req_rw    = 2'b11;
        rem[0]    = 3;
        rem[1]    = 3;
        idx       = 0;
        pend      = 1'b0;
        owner     = 0;
        cyc       = 0;
        while ((idx < 6 || pend) && cyc < 100) begin
            tick();
            cyc++;
            clear_dn();
            req_valid = {rem[1] > 0, rem[0] > 0};
            if (pend) begin
                mi_rstb  = 1'b1;
                mi_rlast = 1'b1;
                mi_rdata = 32'hD000 + idx;
                pend     = 1'b0;
                sample();
                check_eq("t2_rstb", req_rstb, (owner == 1) ? 2'b10 : 2'b01);
                check_eq("t2_rlast", req_rlast, (owner == 1) ? 2'b10 : 2'b01);
                check_eq("t2_rdata", req_rdata, 32'hD000 + idx);
            end else begin
                #1;
                if (mi_valid) begin
                    owner = (mi_addr == 32'h2000) ? 1 : 0;
                    check_eq("t2_order", owner, exp_order[idx]);
                    mi_ready = 1'b1;
                    rem[owner]--;
                    idx++;
                    pend = 1'b1;
                end
            end
        end
        check_eq("t2_bursts", idx, 6);
        check_eq("t2_pending", pend, 0);
        tick();
        clear_dn();
        req_valid = '0;
        tick();

        // back-pressure: req1 granted, req0 arrives while mi_ready is held low
        req_addr  = {32'h3000, 32'h4000};
        req_len   = {7'd1, 7'd2};
        req_rw    = 2'b01;
        req_valid = 2'b10;
        tick();
        req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            sample();
            check_eq("t3_bp_valid", mi_valid, 1);
            check_eq("t3_bp_addr", mi_addr, 32'h3000);
            check_eq("t3_bp_len", mi_len, 1);
            check_eq("t3_bp_ready", req_ready, 0);
            tick();
        end
        mi_ready = 1'b1;
        sample();
        check_eq("t3_ready", req_ready, 2'b10);
        tick();
        mi_ready  = 1'b0;
        req_valid = 2'b01;
        for (int i = 0; i < 2; i++) begin
            mi_wack  = 1'b1;
            mi_wlast = (i == 1);
            sample();
            check_eq("t3_wack", req_wack, 2'b10);
            tick();
        end
        clear_dn();
        sample();
        check_eq("t3_gap_idle", mi_valid, 0);
        tick();
        sample();
        check_eq("t3_next_valid", mi_valid, 1);
        check_eq("t3_next_addr", mi_addr, 32'h4000);

        // abort: req0 withdraws in CMD, req1 is served next
        tick();
        req_addr[63:32] = 32'h5000;
        req_len[13:7]   = 7'd0;
        req_rw[1]       = 1'b1;
        req_valid       = 2'b10;
        sample();
        check_eq("t4_drop_valid", mi_valid, 0);
        tick();
        sample();
        check_eq("t4_idle_valid", mi_valid, 0);
        check_eq("t4_idle_addr", mi_addr, 0);
        tick();
        mi_ready = 1'b1;
        sample();
        check_eq("t4_cmd_valid", mi_valid, 1);
        check_eq("t4_cmd_addr", mi_addr, 32'h5000);
        check_eq("t4_cmd_ready", req_ready, 2'b10);
        tick();
        mi_ready  = 1'b0;
        req_valid = '0;
        mi_wack   = 1'b1;
        mi_wlast  = 1'b1;
        sample();
        tick();
        clear_dn();
        mi_rstb  = 1'b1;
        mi_rlast = 1'b1;
        mi_rdata = 32'hBEEF;
        sample();
        check_eq("t4_wr_ignored", mi_addr, 32'h5000);
        check_eq("t4_rstb", req_rstb, 2'b10);
        check_eq("t4_rdata", req_rdata, 32'hBEEF);
        tick();
        clear_dn();
        sample();
        check_eq("t4_end_idle", mi_addr, 0);

        // reset mid-read, then a clean write whose last beat lands on the accept
        tick();
        req_addr[31:0] = 32'h6000;
        req_len[6:0]   = 7'd3;
        req_rw[0]      = 1'b1;
        req_valid      = 2'b01;
        tick();
        mi_ready = 1'b1;
        tick();
        mi_ready  = 1'b0;
        req_valid = '0;
        mi_rstb   = 1'b1;
        mi_rdata  = 32'h1234;
        sample();
        check_eq("t5_rstb", req_rstb, 2'b01);
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_rstb", req_rstb, 0);
        check_eq("t5_rst_addr", mi_addr, 0);
        check_eq("t5_rst_rdata", req_rdata, 0);
        check_eq("t5_rst_valid", mi_valid, 0);
        clear_dn();
        tick();
        rst_n = 1'b1;
        tick();
        req_addr[31:0]  = 32'h7000;
        req_len[6:0]    = 7'd0;
        req_rw[0]       = 1'b0;
        req_wdata[31:0] = 32'h55;
        req_valid       = 2'b01;
        sample();
        check_eq("t5_post_idle", mi_valid, 0);
        tick();
        mi_ready = 1'b1;
        mi_wack  = 1'b1;
        mi_wlast = 1'b1;
        sample();
        check_eq("t5_post_valid", mi_valid, 1);
        check_eq("t5_post_addr", mi_addr, 32'h7000);
        check_eq("t5_post_ready", req_ready, 2'b01);
        check_eq("t5_post_wack", req_wack, 2'b01);
        check_eq("t5_post_wdata", mi_wdata, 32'h55);
        tick();
        req_valid = '0;
        clear_dn();
        sample();
        check_eq("t5_direct_idle", mi_addr, 0);
        check_eq("t5_direct_valid", mi_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
